// File: rtl/attn_out_collector.sv
// Output sink of the 4x4 MHA attention pipeline: writes beats into the output SRAM at
// {group,row}, tracks completion/errors, serves readback. Define ATTN_OUT_DUPCHK_EN for duplicate-address checking.
//
// state   | meaning
// IDLE    | after reset, readback allowed, beats ignored
// CAPTURE | beats accepted and written one cycle later
// FLUSH   | one cycle for the write of a beat that arrived with in_done
// DONE    | capture finished, readback allowed, beats ignored
module attn_out_collector #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned ROW_W    = 2,
    parameter int unsigned GRP_W    = 5,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [ROW_W-1:0]  in_row_i,
    input  logic [GRP_W-1:0]  in_group_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_done_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_web_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              busy_o,
    output logic              complete_o,
    output logic [7:0]        count_o,
    output logic              err_early_o,
    output logic              err_dup_o
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [7:0]  FULL_CNT = 8'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_web_q, mem_web_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic [READ_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                busy_q, busy_d;
    logic                complete_q, complete_d;
    logic [7:0]          count_q, count_d;
    logic                err_early_q, err_early_d;

    logic              beat_acc;
    logic              beat_new;
    logic              rd_acc;
    logic [ADDR_W-1:0] beat_addr;

    assign beat_acc  = (state_q == S_CAPTURE) && in_valid_i && !start_i;
    assign rd_acc    = ((state_q == S_IDLE) || (state_q == S_DONE)) && rd_req_i;
    assign beat_addr = {in_group_i, in_row_i};

`ifdef ATTN_OUT_DUPCHK_EN
    logic [DEPTH-1:0] written_q, written_d;
    logic             err_dup_q, err_dup_d;
    logic             beat_dup;

    assign beat_dup = written_q[beat_addr];
    assign beat_new = beat_acc && !beat_dup;

    always_comb begin
        written_d = written_q;
        err_dup_d = err_dup_q;
        if (start_i) begin
            written_d = '0;
            err_dup_d = 1'b0;
        end else if (beat_acc) begin
            written_d[beat_addr] = 1'b1;
            err_dup_d            = err_dup_q | beat_dup;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
            err_dup_q <= 1'b0;
        end else begin
            written_q <= written_d;
            err_dup_q <= err_dup_d;
        end
    end

    assign err_dup_o = err_dup_q;
`else
    assign beat_new  = beat_acc;
    assign err_dup_o = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = S_CAPTURE;
        end else begin
            case (state_q)
                S_CAPTURE: if (in_done_i) state_d = S_FLUSH;
                S_FLUSH:   state_d = S_DONE;
                default:   state_d = state_q;
            endcase
        end
    end

    // FSM: outputs, computed from next state so the registered flags line up with it
    always_comb begin
        busy_d     = (state_d == S_CAPTURE) || (state_d == S_FLUSH);
        complete_d = (state_d == S_DONE) && (count_d == FULL_CNT);
    end

    always_comb begin
        count_d     = count_q;
        err_early_d = err_early_q;
        if (start_i) begin
            count_d     = '0;
            err_early_d = 1'b0;
        end else begin
            if (beat_new && (count_q != FULL_CNT)) count_d = count_q + 8'd1;
            if ((state_q == S_CAPTURE) && in_done_i && (count_d < FULL_CNT))
                err_early_d = 1'b1;
        end
    end

    always_comb begin
        mem_web_d  = 1'b1;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if (beat_acc) begin
            mem_web_d  = 1'b0;
            mem_addr_d = beat_addr;
            mem_din_d  = in_data_i;
        end else if (rd_acc) begin
            mem_addr_d = rd_addr_i;
        end
    end

    // Request marker walks READ_LAT stages; mem_dout is captured on the last one,
    // so rd_valid rises 1+READ_LAT cycles after rd_req. Not cleared by start.
    always_comb begin
        rd_pipe_d    = rd_pipe_q << 1;
        rd_pipe_d[0] = rd_acc;
        rd_data_d    = rd_pipe_q[READ_LAT-1] ? mem_dout_i : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q  <= '0;
            mem_web_q   <= 1'b1;
            mem_din_q   <= '0;
            rd_pipe_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            complete_q  <= 1'b0;
            count_q     <= '0;
            err_early_q <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_web_q   <= mem_web_d;
            mem_din_q   <= mem_din_d;
            rd_pipe_q   <= rd_pipe_d;
            rd_valid_q  <= rd_pipe_q[READ_LAT-1];
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
            complete_q  <= complete_d;
            count_q     <= count_d;
            err_early_q <= err_early_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_web_o   = mem_web_q;
    assign mem_din_o   = mem_din_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign busy_o      = busy_q;
    assign complete_o  = complete_q;
    assign count_o     = count_q;
    assign err_early_o = err_early_q;

endmodule

// File: tb/tb_attn_out_collector.sv
// Directed bench for attn_out_collector with a synchronous SRAM model (one register
// stage, matching READ_LAT=2 as seen from the collector).
module tb_attn_out_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, in_valid, in_done, rd_req;
    logic [1:0]   in_row;
    logic [4:0]   in_group;
    logic [127:0] in_data;
    logic [6:0]   mem_addr, rd_addr;
    logic         mem_web;
    logic [127:0] mem_din, mem_dout, rd_data;
    logic         rd_valid, busy, complete, err_early, err_dup;
    logic [7:0]   count;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_cnt = 0;

`ifdef ATTN_OUT_DUPCHK_EN
    localparam logic EXP_DUP = 1'b1;
`else
    localparam logic EXP_DUP = 1'b0;
`endif

    always #5 clk = ~clk;

    attn_out_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .in_valid_i (in_valid),
        .in_row_i   (in_row),
        .in_group_i (in_group),
        .in_data_i  (in_data),
        .in_done_i  (in_done),
        .mem_addr_o (mem_addr),
        .mem_web_o  (mem_web),
        .mem_din_o  (mem_din),
        .mem_dout_i (mem_dout),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .busy_o     (busy),
        .complete_o (complete),
        .count_o    (count),
        .err_early_o(err_early),
        .err_dup_o  (err_dup)
    );

    logic [127:0] mem [128];

    always @(posedge clk) begin
        if (!mem_web) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    always @(posedge clk) if (rst_n && !mem_web) wr_cnt <= wr_cnt + 1;

    function automatic logic [127:0] beat(input int g, input int r, input int salt);
        logic [31:0] w;
        w = {8'(salt), 8'hA5, 8'(g), 8'(r)};
        return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd1};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " mem_web"},   mem_web,   1);
        chk({tag, " mem_addr"},  mem_addr,  0);
        chk({tag, " mem_din"},   mem_din,   0);
        chk({tag, " rd_valid"},  rd_valid,  0);
        chk({tag, " rd_data"},   rd_data,   0);
        chk({tag, " count"},     count,     0);
        chk({tag, " err_early"}, err_early, 0);
        chk({tag, " err_dup"},   err_dup,   0);
        chk({tag, " busy"},      busy,      0);
        chk({tag, " complete"},  complete,  0);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input int g, input int r, input int salt);
        in_valid = 1'b1;
        in_group = 5'(g);
        in_row   = 2'(r);
        in_data  = beat(g, r, salt);
        step();
    endtask

    task automatic send_seq(input int n, input int salt, input bit chk_wr);
        for (int i = 0; i < n; i++) begin
            send(i / 4, i % 4, salt);
            if (chk_wr) begin
                chk("wr web", mem_web, 0);
                chk("wr addr", mem_addr, 128'(i));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_done();
        in_done = 1'b1;
        step();
        in_done = 1'b0;
    endtask

    task automatic read_expect(input int a, input logic [127:0] exp);
        rd_req  = 1'b1;
        rd_addr = 7'(a);
        step();
        rd_req  = 1'b0;
        chk("rd T+1 valid", rd_valid, 0);
        step();
        chk("rd T+2 valid", rd_valid, 0);
        step();
        chk("rd T+3 valid", rd_valid, 1);
        chk("rd T+3 data", rd_data, exp);
        step();
        chk("rd T+4 valid", rd_valid, 0);
    endtask

    initial begin
        int base;
        int seen;
        rst_n = 1'b0;
        start = 0; in_valid = 0; in_done = 0; rd_req = 0;
        in_row = 0; in_group = 0; in_data = '0; rd_addr = '0;
        repeat (3) step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();

        // full capture, in_done on its own cycle
        base = wr_cnt;
        do_start();
        chk("cap busy", busy, 1);
        send_seq(128, 0, 1'b1);
        do_done();
        chk("flush busy", busy, 1);
        chk("flush no write", mem_web, 1);
        step();
        chk("full complete", complete, 1);
        chk("full busy", busy, 0);
        chk("full count", count, 128);
        chk("full err_early", err_early, 0);
        chk("full err_dup", err_dup, 0);
        chk("full writes", 128'(wr_cnt - base), 128);
        send(5, 0, 9);
        in_valid = 1'b0;
        chk("done beat ignored", mem_web, 1);

        // readback, single and back-to-back
        read_expect(5, beat(1, 1, 0));
        read_expect(66, beat(16, 2, 0));
        rd_req = 1'b1; rd_addr = 7'd0;
        step();
        rd_addr = 7'd127;
        step();
        rd_req = 1'b0;
        step();
        chk("b2b first valid", rd_valid, 1);
        chk("b2b first data", rd_data, beat(0, 0, 0));
        step();
        chk("b2b second valid", rd_valid, 1);
        chk("b2b second data", rd_data, beat(31, 3, 0));
        step();
        chk("b2b end valid", rd_valid, 0);

        // start-cycle beat dropped, then early done after 100 beats
        start = 1'b1; in_valid = 1'b1; in_group = 0; in_row = 0; in_data = beat(0, 0, 1);
        step();
        start = 1'b0; in_valid = 1'b0;
        chk("start beat web", mem_web, 1);
        chk("start count", count, 0);
        chk("start complete", complete, 0);
        send_seq(100, 1, 1'b0);
        do_done();
        step();
        chk("early count", count, 100);
        chk("early err_early", err_early, 1);
        chk("early complete", complete, 0);
        chk("early busy", busy, 0);

        // duplicate (g3,r2) among 129 beats
        do_start();
        chk("restart count", count, 0);
        chk("restart err_early", err_early, 0);
        for (int i = 0; i < 128; i++) begin
            send(i / 4, i % 4, 2);
            if (i == 63) send(3, 2, 3);
        end
        in_valid = 1'b0;
        do_done();
        step();
        chk("dup count", count, 128);
        chk("dup err_dup", err_dup, EXP_DUP);
        chk("dup complete", complete, 1);
        chk("dup err_early", err_early, 0);
        read_expect(14, beat(3, 2, 3));
        read_expect(15, beat(3, 3, 2));

        // last beat coincident with in_done
        do_start();
        chk("clear err_dup", err_dup, 0);
        send_seq(127, 0, 1'b0);
        in_valid = 1'b1; in_group = 5'd31; in_row = 2'd3; in_data = beat(31, 3, 0);
        in_done = 1'b1;
        step();
        in_valid = 1'b0; in_done = 1'b0;
        chk("coinc flush busy", busy, 1);
        chk("coinc flush web", mem_web, 0);
        chk("coinc flush addr", mem_addr, 127);
        chk("coinc flush din", mem_din, beat(31, 3, 0));
        chk("coinc flush complete", complete, 0);
        step();
        chk("coinc complete", complete, 1);
        chk("coinc busy", busy, 0);
        chk("coinc count", count, 128);
        chk("coinc err_early", err_early, 0);

        // readback dropped during capture, then async reset mid-capture
        do_start();
        send_seq(50, 7, 1'b0);
        rd_req = 1'b1; rd_addr = 7'd3;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            rd_req = 1'b0;
            if (rd_valid) seen++;
        end
        chk("capture rd_valid seen", 128'(seen), 0);
        chk("capture count", count, 50);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midreset");
        step();
        step();
        rst_n = 1'b1;
        step();
        read_expect(0, beat(0, 0, 7));
        read_expect(60, beat(15, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
